// File: rtl/my_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : my_lfsr_gen
//  Description : Fibonacci LFSR generator with seed load, zero-seed lockup
//                protection, wrap detection and period measurement.
//  Revision    : 1.0 - initial release
// ============================================================================
module my_lfsr_gen #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
    parameter logic [WIDTH-1:0] RESET_SEED = 8'h47
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED,
    output logic             Dout,
    output logic [WIDTH-1:0] Q,
    output logic             WRAP,
    output logic [WIDTH-1:0] PERIOD,
    output logic             LOCKUP
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_wrap;
    logic             r_lockup;

    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_hit_ref;

    // Feedback, next shifted state and wrap detection for a single step.
    always_comb begin
        w_fb      = ^(r_state & TAPS);
        w_next    = {r_state[WIDTH-2:0], w_fb};
        w_cnt_inc = r_cnt + c_one;
        w_hit_ref = (w_next == r_ref);
    end

    // State, reference, step counter and status pulses; LOAD beats EN beats hold.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= RESET_SEED;
            r_ref    <= RESET_SEED;
            r_cnt    <= c_zero;
            r_period <= c_zero;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else if (LOAD) begin
            // A zero seed would freeze the register forever, so fall back
            // to the reset seed and flag the rejection.
            if (SEED != c_zero) begin
                r_state  <= SEED;
                r_ref    <= SEED;
                r_lockup <= 1'b0;
            end else begin
                r_state  <= RESET_SEED;
                r_ref    <= RESET_SEED;
                r_lockup <= 1'b1;
            end
            r_cnt    <= c_zero;
            r_period <= c_zero;
            r_wrap   <= 1'b0;
        end else if (EN) begin
            r_state  <= w_next;
            r_lockup <= 1'b0;
            if (w_hit_ref) begin
                r_wrap   <= 1'b1;
                r_period <= w_cnt_inc;
                r_cnt    <= c_zero;
            end else begin
                r_wrap   <= 1'b0;
                r_cnt    <= w_cnt_inc;
            end
        end else begin
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end
    end

    // Outputs are direct views of the registers.
    always_comb begin
        Dout   = r_state[WIDTH-1];
        Q      = r_state;
        WRAP   = r_wrap;
        PERIOD = r_period;
        LOCKUP = r_lockup;
    end

endmodule
`default_nettype wire

// File: tb/tb_my_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_lfsr_gen
//  Description : Scoreboard testbench for my_lfsr_gen at default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_lfsr_gen;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       LOAD;
    logic [7:0] SEED;
    logic       Dout;
    logic [7:0] Q;
    logic       WRAP;
    logic [7:0] PERIOD;
    logic       LOCKUP;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic       wrap;
        logic [7:0] period;
        logic       lockup;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   step_id = 0;

    my_lfsr_gen dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .LOAD   (LOAD),
        .SEED   (SEED),
        .Dout   (Dout),
        .Q      (Q),
        .WRAP   (WRAP),
        .PERIOD (PERIOD),
        .LOCKUP (LOCKUP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog: the run is a few hundred cycles long.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, id, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic [7:0] m;
        m = s & 8'hB8;
        return {s[6:0], ^m};
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after that edge.
    task automatic cyc(input logic en, input logic load, input logic [7:0] seed,
                       input logic [7:0] eq, input logic ew, input logic [7:0] ep, input logic el);
        exp_t e;
        @(negedge CLK);
        EN   = en;
        LOAD = load;
        SEED = seed;
        @(posedge CLK);
        step_id++;
        e.q      = eq;
        e.wrap   = ew;
        e.period = ep;
        e.lockup = el;
        e.id     = step_id;
        sb.push_back(e);
    endtask

    // Monitor: after every edge, compare the DUT against the oldest expectation.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q",      e.id, 32'(Q),      32'(e.q));
            chk("dout",   e.id, 32'(Dout),   32'(e.q[7]));
            chk("wrap",   e.id, 32'(WRAP),   32'(e.wrap));
            chk("period", e.id, 32'(PERIOD), 32'(e.period));
            chk("lockup", e.id, 32'(LOCKUP), 32'(e.lockup));
        end
    end

    initial begin
        logic [7:0] m_q;
        RST  = 1'b0;
        EN   = 1'b0;
        LOAD = 1'b0;
        SEED = 8'h00;

        // Held in reset for 5 cycles, even with EN high on some of them.
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 8'h47, 1'b0, 8'd0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 8'h00, 8'h47, 1'b0, 8'd0, 1'b0);
        @(negedge CLK);
        EN  = 1'b0;
        RST = 1'b1;

        // First steps after reset, hand-computed.
        cyc(1'b1, 1'b0, 8'h00, 8'h8E, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 8'h1C, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 8'h38, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 8'h71, 1'b0, 8'd0, 1'b0);

        // Rest of the first full period: single wrap on step 255.
        m_q = 8'h71;
        for (int i = 5; i <= 255; i++) begin
            m_q = lfsr_next(m_q);
            cyc(1'b1, 1'b0, 8'h00, m_q, (i == 255), (i == 255) ? 8'd255 : 8'd0, 1'b0);
        end
        chk("wrap_returns_seed", step_id, 32'(m_q), 32'h47);

        // Second period with a 3-cycle freeze in the middle.
        for (int i = 1; i <= 255; i++) begin
            m_q = lfsr_next(m_q);
            cyc(1'b1, 1'b0, 8'h00, m_q, (i == 255), 8'd255, 1'b0);
            if (i == 100) begin
                repeat (3) cyc(1'b0, 1'b0, 8'h00, m_q, 1'b0, 8'd255, 1'b0);
            end
        end
        cyc(1'b1, 1'b0, 8'h00, 8'h8E, 1'b0, 8'd255, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 8'h1C, 1'b0, 8'd255, 1'b0);

        // Asynchronous reset between edges takes effect immediately.
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_q",      step_id, 32'(Q),      32'h47);
        chk("async_rst_period", step_id, 32'(PERIOD), 32'h0);
        chk("async_rst_dout",   step_id, 32'(Dout),   32'h0);
        cyc(1'b0, 1'b0, 8'h00, 8'h47, 1'b0, 8'd0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        cyc(1'b1, 1'b0, 8'h00, 8'h8E, 1'b0, 8'd0, 1'b0);

        // Load with EN high: load wins, no step that cycle.
        cyc(1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 8'd0, 1'b0);

        // Zero seed is rejected: reset seed loaded, one-cycle LOCKUP.
        cyc(1'b0, 1'b1, 8'h00, 8'h47, 1'b0, 8'd0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 8'h47, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, 1'b1, 8'h00, 8'h47, 1'b0, 8'd0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 8'h8E, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 8'h8E, 1'b0, 8'd0, 1'b0);

        // Drain the scoreboard, bounded.
        repeat (3) @(posedge CLK);
        #2;
        chk("scoreboard_drained", step_id, 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
